// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and default width shared by the mul/div ALU
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_NEG  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHRA = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_SHR  = 4'd12;

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    DIV_RUN,
    DIV_FIX
  } alu_state_e;

endpackage

// File: rtl/mul_div_alu_if.sv
// rtl/mul_div_alu_if.sv - start/done request and HI/LO result bundle between control unit and ALU
interface mul_div_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  logic             illegal_op;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero, illegal_op
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero, illegal_op
  );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned restoring divider core, one quotient bit per step
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] q, r, d;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] diff;

  // The partial remainder stays below the divisor, so the difference fits in WIDTH bits.
  assign trial = {r, q[WIDTH-1]};
  assign fits  = trial >= {1'b0, d};
  assign diff  = trial[WIDTH-1:0] - d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
      r <= '0;
      d <= '0;
    end else if (load) begin
      q <= dividend;
      r <= '0;
      d <= divisor;
    end else if (step) begin
      r <= fits ? diff : trial[WIDTH-1:0];
      q <= {q[WIDTH-2:0], fits};
    end
  end

  assign quotient  = q;
  assign remainder = r;

endmodule

// File: rtl/mul_div_alu.sv
// rtl/mul_div_alu.sv - multi-cycle ALU: single-cycle logic/shift ops, Booth multiply, signed divide
module mul_div_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = ALU_WIDTH,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         clr,
  mul_div_alu_if.slave bus
);

  alu_state_e       state, state_n;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   n;
  logic [SHW:0]     inv_n;
  logic             last_iter, div_go, accept;

  logic [WIDTH:0]   acc, mcand, acc_sum, acc_n;
  logic [WIDTH-1:0] mq, mq_n;
  logic             booth_e;

  logic             neg_q, neg_r;
  logic [WIDTH-1:0] mag_a, mag_b, quot, rem;

  logic [WIDTH-1:0] sc_lo, sc_hi;
  logic             sc_dbz, sc_ill;

  logic [WIDTH-1:0] hi_r, lo_r;
  logic             done_r, dbz_r, ill_r;

  assign n         = bus.b[SHW-1:0];
  assign inv_n     = (SHW+1)'(WIDTH) - {1'b0, n};
  assign last_iter = cnt == SHW'(WIDTH - 1);
  assign accept    = (state == IDLE) && bus.start;
  assign div_go    = (bus.op == OP_DIV) && (bus.b != '0);
  assign mag_a     = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign mag_b     = bus.b[WIDTH-1] ? -bus.b : bus.b;

  always_comb begin
    sc_lo  = '0;
    sc_hi  = '0;
    sc_dbz = 1'b0;
    sc_ill = 1'b0;
    case (bus.op)
      OP_AND:  sc_lo = bus.a & bus.b;
      OP_OR:   sc_lo = bus.a | bus.b;
      OP_ADD:  sc_lo = bus.a + bus.b;
      OP_SUB:  sc_lo = bus.a - bus.b;
      OP_NEG:  sc_lo = -bus.b;
      OP_NOT:  sc_lo = ~bus.b;
      OP_SHL:  sc_lo = bus.a << n;
      OP_SHRA: sc_lo = $signed(bus.a) >>> n;
      OP_SHR:  sc_lo = bus.a >> n;
      // A shift by inv_n == WIDTH yields zero, which makes n == 0 a plain copy.
      OP_ROL:  sc_lo = (bus.a << n) | (bus.a >> inv_n);
      OP_ROR:  sc_lo = (bus.a >> n) | (bus.a << inv_n);
      OP_MUL:  sc_lo = '0;
      OP_DIV: begin
        sc_lo  = '1;
        sc_hi  = bus.a;
        sc_dbz = 1'b1;
      end
      default: sc_ill = 1'b1;
    endcase
  end

  always_comb begin
    acc_sum = acc;
    case ({mq[0], booth_e})
      2'b10:   acc_sum = acc - mcand;
      2'b01:   acc_sum = acc + mcand;
      default: acc_sum = acc;
    endcase
  end

  assign acc_n = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
  assign mq_n  = {acc_sum[0], mq[WIDTH-1:1]};

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .clr       (clr),
    .load      (accept && div_go),
    .step      (state == DIV_RUN),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quot),
    .remainder (rem)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (bus.start && bus.op == OP_MUL) state_n = MUL_RUN;
        else if (bus.start && div_go)      state_n = DIV_RUN;
      end
      MUL_RUN: if (last_iter) state_n = IDLE;
      DIV_RUN: if (last_iter) state_n = DIV_FIX;
      DIV_FIX: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mq      <= '0;
      booth_e <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
      ill_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MUL) begin
              acc     <= '0;
              mcand   <= {bus.a[WIDTH-1], bus.a};
              mq      <= bus.b;
              booth_e <= 1'b0;
              cnt     <= '0;
            end else if (div_go) begin
              neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              neg_r <= bus.a[WIDTH-1];
              cnt   <= '0;
            end else begin
              hi_r   <= sc_hi;
              lo_r   <= sc_lo;
              dbz_r  <= sc_dbz;
              ill_r  <= sc_ill;
              done_r <= 1'b1;
            end
          end
        end
        MUL_RUN: begin
          acc     <= acc_n;
          mq      <= mq_n;
          booth_e <= mq[0];
          cnt     <= cnt + SHW'(1);
          // The final iteration writes straight into HI/LO so done lands in cycle WIDTH+1.
          if (last_iter) begin
            hi_r   <= acc_n[WIDTH-1:0];
            lo_r   <= mq_n;
            dbz_r  <= 1'b0;
            ill_r  <= 1'b0;
            done_r <= 1'b1;
          end
        end
        DIV_RUN: cnt <= cnt + SHW'(1);
        DIV_FIX: begin
          lo_r   <= neg_q ? -quot : quot;
          hi_r   <= neg_r ? -rem : rem;
          dbz_r  <= 1'b0;
          ill_r  <= 1'b0;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = state != IDLE;
  assign bus.done        = done_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.illegal_op  = ill_r;

endmodule

// File: doc/mul_div_alu.md
# mul_div_alu

- Parametrised, multi-cycle ALU: the next-generation datapath ALU.
- Keeps the single-cycle logic, add/sub, shift and rotate operations.
- Replaces combinational multiply with a sequential radix-2 Booth multiplier.
- Adds a sequential signed divider, producing a 2·WIDTH result in HI/LO registers.
- Sits between the register-file read ports and the HI/LO/Z writeback path; the control unit sequences it with a start/done handshake.

## Interface
- WIDTH, 32: operand width; ≥ 4, power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived; not overridden).
- clk  in  1  rising-edge clock
- clr  in  1  reset, asynchronous, active-high
- start  in  1  operation request; sampled only when busy=0
- op  in  4  operation code (encodings in Operation)
- a  in  WIDTH  operand A; shift/rotate source, multiplicand, dividend
- b  in  WIDTH  operand B; shift amount (b[SHW-1:0]), multiplier, divisor
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle pulse: hi/lo/flags updated this cycle
- hi  out  WIDTH  upper product / remainder; 0 for single-cycle ops
- lo  out  WIDTH  result, lower product, quotient
- div_by_zero  out  1  last DIV had b=0; held until next done
- illegal_op  out  1  last op was 13–15; held until next done

## Operation
- Op codes:
  - 0 AND; 1 OR; 2 ADD (mod 2^WIDTH); 3 SUB a−b; 4 NEG −b; 5 NOT ~b (bitwise).
  - 6 SHL a<<n; 7 SHRA a>>>n (arithmetic); 8 ROL a by n; 9 ROR a by n; 12 SHR logical; n=b[SHW-1:0].
  - 10 MUL signed a×b → {hi,lo} full 2·WIDTH.
  - 11 DIV signed: lo=quotient truncated toward zero; hi=remainder with the sign of a.
  - 13–15 illegal: lo=hi=0, illegal_op=1.
- FSM states: IDLE, MUL_RUN, DIV_RUN, DIV_FIX.
- IDLE + start + single-cycle op (incl. illegal, DIV with b=0):
  - register the result; assert done next cycle; stay IDLE; busy never rises.
- IDLE + start + MUL:
  - load the accumulator (WIDTH+1 bits, so −2^(W−1)·−2^(W−1) is exact), Booth bit E=0, counter=0.
  - go to MUL_RUN.
  - Each MUL_RUN cycle: examine {multiplier LSB, E}, add or subtract the multiplicand, then one arithmetic right shift.
  - After WIDTH iterations: write hi/lo, pulse done, return to IDLE.
- IDLE + start + DIV with b≠0:
  - latch signs; load |a| and |b| (most-negative magnitude held in WIDTH+1 bits); go to DIV_RUN.
  - DIV_RUN: WIDTH restoring iterations, one quotient bit per cycle, then DIV_FIX.
  - DIV_FIX: apply signs; write hi/lo; pulse done; return to IDLE.
- DIV by zero: lo=all ones, hi=a, div_by_zero=1; single-cycle path.
- DIV overflow (−2^(W−1) / −1): lo=−2^(W−1) (wraps), hi=0; no flag.
- start while busy=1: ignored; op/a/b are not re-sampled.
- a, b, op are captured at start; changes during busy have no effect.
- hi/lo/flags hold their values between done pulses.

## Timing
- Cycle 0 = cycle in which start is sampled high with busy=0.
- Single-cycle ops: done=1 in cycle 1.
- MUL: busy=1 in cycles 1..WIDTH; done=1 and busy=0 in cycle WIDTH+1.
- DIV: busy=1 in cycles 1..WIDTH+1; done=1 and busy=0 in cycle WIDTH+2.
- Back-to-back: start may be high in the same cycle as done; it is accepted, giving no bubble.
- Reset values (clr asserted): busy=0, done=0, hi=0, lo=0, div_by_zero=0, illegal_op=0, state=IDLE, counter=0.
- clr mid-operation: abort immediately; no done pulse; outputs go to their reset values.

## Structure
- Shared package alu_pkg:
  - op-code localparams (OP_AND … OP_SHR);
  - state enum (IDLE, MUL_RUN, DIV_RUN, DIV_FIX);
  - WIDTH default constant.
- One sub-module, seq_divider: the unsigned restoring core, with load/step/remainder/quotient ports and a WIDTH parameter.
- The Booth multiplier and the single-cycle ops stay in the top level.

## Test plan
- MUL a=−7 (FFFFFFF9), b=3: expect hi=FFFFFFFF, lo=FFFFFFEB, busy for 32 cycles, done in cycle 33.
- MUL a=b=80000000: expect hi=40000000, lo=00000000.
- DIV a=−7, b=2: expect lo=FFFFFFFD, hi=FFFFFFFF, done in cycle 34.
- DIV a=5, b=0: expect done in cycle 1, lo=FFFFFFFF, hi=00000005, div_by_zero=1.
- ROL a=80000001, b=4: expect lo=00000018, hi=0, done in cycle 1.
- SHRA a=80000000, b=31: expect lo=FFFFFFFF.
- op=14: expect lo=hi=0, illegal_op=1, done in cycle 1.
- Start MUL, raise start again in cycle 5 with op=ADD: expect it ignored and the MUL result unchanged.
- Start MUL, assert clr in cycle 10: expect busy=0 and hi=lo=0 immediately, and no done pulse.
- After reset, back-to-back ADD 2+3 then SUB 2−3, start held high: expect done in consecutive cycles with lo=00000005 then lo=FFFFFFFF.
